// File: rtl/elevator_pkg.sv
// Shared elevator control types: door FSM state encoding and default timing constants.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } door_state_e;

    localparam int DOOR_CNT_W        = 4;
    localparam int DOOR_HOLD_DEFAULT = 3;
    localparam int DOOR_PRESCALE     = 1;
    localparam int DOOR_MAX_REOPEN   = 3;

    // A divide-by-1 prescaler still needs a one-bit register.
    function automatic int presc_width(input int presc);
        return (presc > 1) ? $clog2(presc) : 1;
    endfunction

endpackage

// File: rtl/door_tick_gen.sv
// Tick prescaler: pulses tick_o on the cycle its counter reaches PRESCALE-1 while enabled.
// Clear wins over enable and restarts the tick period from zero.
module door_tick_gen
    import elevator_pkg::*;
#(
    parameter int PRESCALE = DOOR_PRESCALE
) (
    input  logic clk,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int PW = presc_width(PRESCALE);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick_o = enable_i && (presc_q == PW'(PRESCALE - 1));

    always_comb begin
        presc_d = presc_q;
        if (clear_i || tick_o) begin
            presc_d = '0;
        end else if (enable_i) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        presc_q <= presc_d;
    end

endmodule

// File: rtl/door_hold_timer.sv
// Door hold timer: IDLE/RUN/DONE FSM counting prescaled ticks up to a latched hold length,
// with bounded restarts on hold_req (nudge once exhausted), early close on cancel, one-cycle done pulse.
module door_hold_timer
    import elevator_pkg::*;
#(
    parameter int CNT_W        = DOOR_CNT_W,
    parameter int HOLD_DEFAULT = DOOR_HOLD_DEFAULT,
    parameter int PRESCALE     = DOOR_PRESCALE,
    parameter int MAX_REOPEN   = DOOR_MAX_REOPEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] hold_time,
    input  logic             hold_req,
    input  logic             cancel,
    output logic             door_open,
    output logic             timer_done,
    output logic             nudge,
    output logic [CNT_W-1:0] count
);

    localparam int RW = $clog2(MAX_REOPEN + 1);

    door_state_e      state_q,    state_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [CNT_W-1:0] hold_val_q, hold_val_d;
    logic [RW-1:0]    reopen_q,   reopen_d;

    logic tick;
    logic run;
    logic reopen_full;
    logic restart;
    logic launch;

    assign run         = (state_q == ST_RUN);
    assign reopen_full = (reopen_q == RW'(MAX_REOPEN));
    assign restart     = run && hold_req && !reopen_full;
    // start is honoured from IDLE and DONE alike, giving back-to-back door cycles.
    assign launch      = start && !run;

    door_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk      (clk),
        .enable_i (run),
        .clear_i  (!reset || launch || restart),
        .tick_o   (tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hold_val_d = hold_val_q;
        reopen_d   = reopen_q;
        if (launch) begin
            state_d    = ST_RUN;
            count_d    = '0;
            reopen_d   = '0;
            hold_val_d = (hold_time == '0) ? CNT_W'(HOLD_DEFAULT) : hold_time;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    // Restart beats cancel, and cancel beats tick, so a cancelled count stays put.
                    if (restart) begin
                        count_d  = '0;
                        reopen_d = reopen_q + RW'(1);
                    end else if (cancel) begin
                        state_d = ST_DONE;
                    end else if (tick) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_d == hold_val_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            hold_val_q <= CNT_W'(HOLD_DEFAULT);
            reopen_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hold_val_q <= hold_val_d;
            reopen_q   <= reopen_d;
        end
    end

    assign door_open  = (state_q != ST_IDLE);
    assign timer_done = (state_q == ST_DONE);
    assign nudge      = door_open && reopen_full;
    assign count      = count_q;

endmodule

// File: tb/tb_door_hold_timer.sv
// Bench for door_hold_timer: default and PRESCALE=4 instances share stimulus; an elapsed-cycle model checks both every edge.
module tb_door_hold_timer;

    localparam int HOLD_DEF = 3;
    localparam int MAXR     = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] hold_time;
    logic       hold_req;
    logic       cancel;

    logic       open_a, done_a, nudge_a;
    logic [3:0] cnt_a;
    logic       open_b, done_b, nudge_b;
    logic [3:0] cnt_b;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    door_hold_timer u_def (
        .clk (clk), .reset (reset), .start (start), .hold_time (hold_time),
        .hold_req (hold_req), .cancel (cancel),
        .door_open (open_a), .timer_done (done_a), .nudge (nudge_a), .count (cnt_a)
    );

    door_hold_timer #(.PRESCALE(4)) u_p4 (
        .clk (clk), .reset (reset), .start (start), .hold_time (hold_time),
        .hold_req (hold_req), .cancel (cancel),
        .door_open (open_b), .timer_done (done_b), .nudge (nudge_b), .count (cnt_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Model tracks cycles elapsed since the last (re)start; count is elapsed / prescale.
    // ph: 0 closed, 1 timing, 2 closing pulse.
    typedef struct {
        int ph;
        int el;
        int hv;
        int reop;
        int cnt;
    } mdl_t;

    function automatic mdl_t mstep(input mdl_t m, input int p, input bit rst_n, input bit st,
                                   input int ht, input bit hr, input bit cc);
        mdl_t n = m;
        if (!rst_n) begin
            n.ph = 0; n.el = 0; n.hv = HOLD_DEF; n.reop = 0; n.cnt = 0;
        end else if (st && m.ph != 1) begin
            n.ph = 1; n.el = 0; n.reop = 0; n.cnt = 0;
            n.hv = (ht == 0) ? HOLD_DEF : ht;
        end else if (m.ph == 2) begin
            n.ph = 0;
        end else if (m.ph == 1) begin
            if (hr && m.reop < MAXR) begin
                n.el = 0; n.cnt = 0; n.reop = m.reop + 1;
            end else if (cc) begin
                n.ph = 2;
            end else begin
                n.el  = m.el + 1;
                n.cnt = n.el / p;
                if (n.el == m.hv * p) n.ph = 2;
            end
        end
        return n;
    endfunction

    mdl_t ma = '{0, 0, HOLD_DEF, 0, 0};
    mdl_t mb = '{0, 0, HOLD_DEF, 0, 0};

    always @(posedge clk) begin
        ma = mstep(ma, 1, reset, start, int'(hold_time), hold_req, cancel);
        mb = mstep(mb, 4, reset, start, int'(hold_time), hold_req, cancel);
        #1;
        chk("a_open",  int'(open_a),  int'(ma.ph != 0));
        chk("a_done",  int'(done_a),  int'(ma.ph == 2));
        chk("a_nudge", int'(nudge_a), int'(ma.ph != 0 && ma.reop == MAXR));
        chk("a_count", int'(cnt_a),   ma.cnt);
        chk("b_open",  int'(open_b),  int'(mb.ph != 0));
        chk("b_done",  int'(done_b),  int'(mb.ph == 2));
        chk("b_nudge", int'(nudge_b), int'(mb.ph != 0 && mb.reop == MAXR));
        chk("b_count", int'(cnt_b),   mb.cnt);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; hold_time = 4'd0; hold_req = 1'b0; cancel = 1'b0;
        cyc(2);
        chk("rst_open", int'(open_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_nudge", int'(nudge_a), 0);
        chk("rst_count", int'(cnt_a), 0);
        reset = 1'b1;

        // Default hold: DONE three edges after RUN entry.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk("def_cnt2", int'(cnt_a), 2);
        chk("def_nodone", int'(done_a), 0);
        cyc(1);
        chk("def_done", int'(done_a), 1);
        chk("def_cnt3", int'(cnt_a), 3);
        cyc(1);
        chk("def_pulse1", int'(done_a), 0);
        chk("def_idle_cnt", int'(cnt_a), 3);
        cyc(12);
        do_reset();

        // PRESCALE=4, hold 5: DONE at edge 20, count steps every 4 edges.
        hold_time = 4'd5;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        hold_time = 4'd0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (k == 19) chk("p4_early", int'(done_b), 0);
            if (k == 20) chk("p4_done", int'(done_b), 1);
            if (k % 4 == 0 && k < 20) chk("p4_step", int'(cnt_b), k / 4);
        end
        cyc(2);
        do_reset();

        // Four hold requests at count=2: three restarts, fourth ignored under nudge.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            cyc(2);
            chk("reo_cnt2", int'(cnt_a), 2);
            hold_req = 1'b1;
            cyc(1);
            hold_req = 1'b0;
            if (r < 3) begin
                chk("reo_clear", int'(cnt_a), 0);
                chk("reo_nudge", int'(nudge_a), int'(r == 2));
            end else begin
                chk("reo_done", int'(done_a), 1);
                chk("reo_cnt3", int'(cnt_a), 3);
                chk("reo_nudge4", int'(nudge_a), 1);
            end
        end
        cyc(1);
        do_reset();

        // Restart beats cancel; cancel alone then closes with count held.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        chk("can_cnt1", int'(cnt_a), 1);
        hold_req = 1'b1; cancel = 1'b1;
        cyc(1);
        chk("can_restart", int'(cnt_a), 0);
        chk("can_open", int'(open_a), 1);
        chk("can_nodone", int'(done_a), 0);
        hold_req = 1'b0;
        cyc(1);
        chk("can_done", int'(done_a), 1);
        chk("can_held", int'(cnt_a), 0);
        cancel = 1'b0;
        cyc(1);
        chk("can_idle", int'(open_a), 0);
        do_reset();

        // Mid-RUN reset, then start held through DONE.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk("mr_cnt2", int'(cnt_a), 2);
        reset = 1'b0;
        cyc(1);
        chk("mr_open", int'(open_a), 0);
        chk("mr_cnt", int'(cnt_a), 0);
        chk("mr_done", int'(done_a), 0);
        reset = 1'b1;
        start = 1'b1;
        cyc(4);
        chk("b2b_done", int'(done_a), 1);
        cyc(1);
        chk("b2b_open", int'(open_a), 1);
        chk("b2b_done0", int'(done_a), 0);
        chk("b2b_cnt", int'(cnt_a), 0);
        start = 1'b0;
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 63) != 0);
            start     = ($urandom_range(0, 5) == 0);
            hold_time = 4'($urandom_range(0, 15));
            hold_req  = ($urandom_range(0, 9) == 0);
            cancel    = ($urandom_range(0, 24) == 0);
            cyc(1);
        end
        reset = 1'b1; start = 1'b0; hold_req = 1'b0; cancel = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/door_hold_timer.md
DOOR_HOLD_TIMER -- requirements
Module: door_hold_timer

Interface
REQ-001 Parameter CNT_W, default 4: width of hold count, hold_time and count.
REQ-002 Parameter HOLD_DEFAULT, default 3: hold length in ticks used when hold_time = 0; legal range 1..2^CNT_W-1.
REQ-003 Parameter PRESCALE, default 1: clock cycles per tick; must be >= 1.
REQ-004 Parameter MAX_REOPEN, default 3: restarts accepted per door cycle before nudge; must be >= 1.
REQ-005 Port: clk  in  1  single system clock, rising edge.
REQ-006 Port: reset  in  1  synchronous, active-low reset.
REQ-007 Port: start  in  1  request door-open timing; level, sampled each edge.
REQ-008 Port: hold_time  in  CNT_W  hold length in ticks, latched on accepted start; 0 selects HOLD_DEFAULT.
REQ-009 Port: hold_req  in  1  door-open button / obstruction; restarts timing.
REQ-010 Port: cancel  in  1  door-close button; ends timing early.
REQ-011 Port: door_open  out  1  high in RUN and DONE.
REQ-012 Port: timer_done  out  1  one-cycle pulse; door may close.
REQ-013 Port: nudge  out  1  high while restarts are exhausted.
REQ-014 Port: count  out  CNT_W  current tick count.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; all outputs SHALL be registered or decoded from state only.
REQ-016 In IDLE, start=1 SHALL latch hold_val and enter RUN with count=0, prescaler=0 and reopen_cnt=0.
REQ-017 In RUN, a tick SHALL occur on every edge where prescaler = PRESCALE-1; the prescaler SHALL then wrap to 0.
REQ-018 Each tick in RUN SHALL increment count by 1; the tick taking count to hold_val SHALL move the FSM to DONE.
REQ-019 Latency SHALL be exactly hold_val*PRESCALE edges from the RUN-entry edge to the DONE-entry edge.
REQ-020 In RUN, hold_req=1 with reopen_cnt < MAX_REOPEN SHALL clear count and prescaler and increment reopen_cnt; this SHALL take priority over tick and cancel.
REQ-021 In RUN, hold_req=1 with reopen_cnt = MAX_REOPEN SHALL be ignored; nudge SHALL be 1 while in RUN or DONE with reopen_cnt = MAX_REOPEN.
REQ-022 In RUN, cancel=1 without an accepted hold_req SHALL enter DONE on the next edge, with count held.
REQ-023 In RUN, start=1 SHALL be ignored.
REQ-024 DONE SHALL last exactly one cycle, with timer_done=1 and door_open=1, then go to IDLE.
REQ-025 In DONE, start=1 SHALL re-enter RUN as in REQ-016 instead of going to IDLE; timer_done SHALL still pulse in that DONE cycle.
REQ-026 In IDLE, count SHALL hold its last value and door_open, timer_done and nudge SHALL be 0; hold_req and cancel SHALL be ignored.
REQ-027 count SHALL never exceed hold_val or wrap; the prescaler width SHALL be max(1, clog2(PRESCALE)).

Reset
REQ-028 When reset=0 at a rising edge, the next state SHALL be IDLE with count=0, prescaler=0, reopen_cnt=0, hold_val=HOLD_DEFAULT, and door_open=timer_done=nudge=0.
REQ-029 Reset SHALL override start, hold_req and cancel, including mid-RUN and in DONE, with no timer_done pulse.

Structure
REQ-030 State encoding (IDLE/RUN/DONE) and default parameter constants SHALL live in the shared elevator_pkg package.
REQ-031 The prescaler SHALL be one sub-module, door_tick_gen, with enable and clear inputs and a tick output; the FSM and counters SHALL stay in door_hold_timer.

Verification
REQ-032 Defaults, start pulse, hold_time=0 -> DONE entered 3 edges after RUN entry; timer_done high for exactly 1 cycle; count=3.
REQ-033 PRESCALE=4, hold_time=5 -> timer_done exactly 20 edges after RUN entry; count steps every 4 cycles.
REQ-034 Defaults, hold_req at count=2, repeated 4 times -> first 3 restarts clear count; 4th is ignored with nudge=1; timer_done 3 ticks after the 3rd restart.
REQ-035 cancel at count=1 together with hold_req -> restart wins and count=0; cancel alone next cycle -> DONE next edge, count=0 held, timer_done pulse.
REQ-036 reset=0 asserted at count=2 in RUN -> next cycle IDLE, count=0, no timer_done pulse; start held through DONE -> back-to-back RUN, no IDLE cycle.
